// File: rtl/alu_pkg.sv
// alu_pkg: shared op indices, FSM states and engine modes for seq_alu
package alu_pkg;
  localparam int CTL_W  = 12;
  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_AND = 2;
  localparam int OP_OR  = 3;
  localparam int OP_SHR = 4;
  localparam int OP_SHL = 5;
  localparam int OP_ROR = 6;
  localparam int OP_ROL = 7;
  localparam int OP_NEG = 8;
  localparam int OP_NOT = 9;
  localparam int OP_MUL = 10;
  localparam int OP_DIV = 11;
  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
  typedef enum logic [1:0] {MODE_MUL = 2'd1, MODE_DIV = 2'd2} mode_t;
endpackage

// File: rtl/seq_muldiv_core.sv
// seq_muldiv_core: magnitude shift-add multiply / restoring divide with sign fix-up
module seq_muldiv_core import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic             step,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] z_low,
  output logic [WIDTH-1:0] z_high
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] hi, lo, mc, mag_a, mag_b;
  logic [CW-1:0] cnt;
  logic is_div, neg_q, neg_r;
  logic [WIDTH:0] sum, sh, diff;
  logic [2*WIDTH-1:0] prod;
  // Operating on magnitudes keeps most-negative inputs exact: 2^(W-1) fits unsigned in W bits.
  assign mag_a = a[WIDTH-1] ? -a : a;
  assign mag_b = b[WIDTH-1] ? -b : b;
  assign sum = lo[0] ? {1'b0, hi} + {1'b0, mc} : {1'b0, hi};
  assign sh = {hi, lo[WIDTH-1]};
  assign diff = sh - {1'b0, mc};
  assign prod = neg_q ? -{hi, lo} : {hi, lo};
  assign last = cnt == '0;
  assign z_low = is_div ? (neg_q ? -lo : lo) : prod[WIDTH-1:0];
  assign z_high = is_div ? (neg_r ? -hi : hi) : prod[2*WIDTH-1:WIDTH];
  // hi/lo act as accumulator/multiplier for MUL and remainder/quotient for DIV
  always_ff @(posedge clock) begin
    if (clear) begin
      {hi, lo, mc, cnt, is_div, neg_q, neg_r} <= '0;
    end else if (load) begin
      hi <= '0;
      lo <= mag_a;
      mc <= mag_b;
      cnt <= CW'(WIDTH - 1);
      is_div <= mode == MODE_DIV;
      neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_r <= a[WIDTH-1];
    end else if (step) begin
      cnt <= cnt - 1'b1;
      hi <= is_div ? (diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
      lo <= is_div ? {lo[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], lo[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: one-hot ALU with single-cycle logic ops and iterative signed MUL/DIV
module seq_alu import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [CTL_W-1:0] alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z_low,
  output logic [WIDTH-1:0] z_high,
  output logic             div_zero,
  output logic             op_error
);
  localparam int SHW = $clog2(WIDTH);
  state_t state;
  logic valid, is_mul, is_div, iter_req, last;
  logic [SHW-1:0] amt, rr, rl;
  logic [WIDTH-1:0] rot, single, core_lo, core_hi;
  assign valid = $onehot(alu_control);
  assign is_mul = alu_control[OP_MUL];
  assign is_div = alu_control[OP_DIV];
  assign iter_req = valid && (is_mul || (is_div && b != '0));
  assign amt = b[SHW-1:0];
  // A left rotate is a right rotate by the negated amount; amount 0 yields a|a = a.
  assign rr = alu_control[OP_ROL] ? -amt : amt;
  assign rl = -rr;
  assign rot = (a >> rr) | (a << rl);
  assign single = alu_control[OP_ADD] ? a + b :
                  alu_control[OP_SUB] ? a - b :
                  alu_control[OP_AND] ? a & b :
                  alu_control[OP_OR]  ? a | b :
                  alu_control[OP_SHR] ? a >> amt :
                  alu_control[OP_SHL] ? a << amt :
                  (alu_control[OP_ROR] | alu_control[OP_ROL]) ? rot :
                  alu_control[OP_NEG] ? -a :
                  alu_control[OP_NOT] ? ~a : '0;
  seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clock (clock),
    .clear (clear),
    .load  (state == IDLE && start && iter_req),
    .step  (state == ITER),
    .mode  (is_div ? MODE_DIV : MODE_MUL),
    .a     (a),
    .b     (b),
    .last  (last),
    .z_low (core_lo),
    .z_high(core_hi)
  );
  // Control FSM: single-cycle results land at the start edge, MUL/DIV go through ITER and FIX
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
      {busy, done, z_low, z_high, div_zero, op_error} <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (iter_req) begin
            state <= ITER;
            busy <= 1'b1;
          end else begin
            done <= 1'b1;
            z_low <= !valid ? '0 : is_div ? '1 : single;
            z_high <= valid && is_div ? a : '0;
            div_zero <= valid && is_div;
            op_error <= !valid;
          end
        end
        ITER: if (last) state <= FIX;
        FIX: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
          z_low <= core_lo;
          z_high <= core_hi;
          div_zero <= 1'b0;
          op_error <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized and directed checks of seq_alu against an arithmetic reference
module tb_seq_alu;
  import alu_pkg::*;
  localparam int W = 32;
  logic clock = 0, clear = 1, start = 0;
  logic [11:0] alu_control = '0;
  logic [W-1:0] a = '0, b = '0, z_low, z_high;
  logic busy, done, div_zero, op_error;
  int tests = 0, fails = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clock(clock), .clear(clear), .start(start), .alu_control(alu_control),
    .a(a), .b(b), .busy(busy), .done(done), .z_low(z_low), .z_high(z_high),
    .div_zero(div_zero), .op_error(op_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    for (int i = 0; i < n; i++) x = {x[30:0], x[31]};
    return x;
  endfunction

  task automatic model(input logic [11:0] ctl, input logic [31:0] ia, input logic [31:0] ib,
                       output logic [31:0] zl, output logic [31:0] zh,
                       output logic dz, output logic oe, output int lat);
    longint sa, sb, r64;
    logic [63:0] v;
    int sh;
    sa = longint'($signed(ia));
    sb = longint'($signed(ib));
    sh = int'(ib % 32);
    zl = 0; zh = 0; dz = 0; oe = 0; lat = 0;
    if ($countones(ctl) != 1) oe = 1;
    else if (ctl[OP_ADD]) zl = ia + ib;
    else if (ctl[OP_SUB]) zl = ia - ib;
    else if (ctl[OP_AND]) zl = ia & ib;
    else if (ctl[OP_OR])  zl = ia | ib;
    else if (ctl[OP_SHR]) zl = ia / (32'd1 << sh);
    else if (ctl[OP_SHL]) zl = ia * (32'd1 << sh);
    else if (ctl[OP_ROR]) zl = rotl(ia, (32 - sh) % 32);
    else if (ctl[OP_ROL]) zl = rotl(ia, sh);
    else if (ctl[OP_NEG]) zl = 32'd0 - ia;
    else if (ctl[OP_NOT]) zl = 32'hFFFFFFFF ^ ia;
    else if (ctl[OP_MUL]) begin
      r64 = sa * sb; v = r64; zl = v[31:0]; zh = v[63:32]; lat = W + 1;
    end else if (ib == 0) begin
      zl = '1; zh = ia; dz = 1;
    end else begin
      r64 = sa / sb; v = r64; zl = v[31:0];
      r64 = sa % sb; v = r64; zh = v[31:0];
      lat = W + 1;
    end
  endtask

  task automatic run(input string tag, input logic [11:0] ctl, input logic [31:0] ia,
                     input logic [31:0] ib, input bit noisy);
    logic [31:0] zl, zh;
    logic dz, oe;
    int lat, n, bn;
    model(ctl, ia, ib, zl, zh, dz, oe, lat);
    alu_control = ctl; a = ia; b = ib; start = 1;
    @(posedge clock); #1;
    start = 0; n = 0; bn = 0;
    if (noisy) begin a = $urandom; b = $urandom; alu_control = 12'($urandom); end
    while (!done && n < 100) begin
      bn += int'(busy);
      if (noisy) start = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      n++;
    end
    start = 0;
    chk({tag, ".lat"}, 64'(n), 64'(lat));
    chk({tag, ".busy_cycles"}, 64'(bn), 64'(lat));
    chk({tag, ".z"}, {z_high, z_low}, {zh, zl});
    chk({tag, ".flags"}, {62'd0, div_zero, op_error}, {62'd0, dz, oe});
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] c [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    return $urandom_range(0, 3) == 0 ? c[$urandom_range(0, 4)] : $urandom;
  endfunction

  initial begin
    int nd;
    logic [11:0] ctl;
    logic [31:0] ra, rb;
    repeat (2) @(posedge clock);
    #1;
    chk("reset", {busy, done, div_zero, op_error, z_high, z_low}, '0);
    clear = 0;
    run("add", 12'h001, 32'h7FFFFFFF, 32'h1, 0);
    run("rol", 12'h080, 32'h80000001, 32'h24, 0);
    run("ror", 12'h040, 32'h80000001, 32'h20, 0);
    run("shr", 12'h010, 32'hF0000000, 32'h4, 0);
    run("mul", 12'h400, 32'hFFFFFFFD, 32'h7, 1);
    run("mul_min", 12'h400, 32'h80000000, 32'h80000000, 0);
    run("div", 12'h800, 32'hFFFFFFEF, 32'h5, 1);
    @(posedge clock); #1;
    chk("done_pulse", 64'(done), 0);
    run("div_min", 12'h800, 32'h80000000, 32'hFFFFFFFF, 0);
    run("div0", 12'h800, 32'd42, 32'h0, 0);
    run("add_clr", 12'h001, 32'd3, 32'd4, 0);
    run("badop", 12'h003, 32'd5, 32'd6, 0);
    run("noop", 12'h000, 32'd5, 32'd6, 0);
    run("mul_pre", 12'h400, 32'hFFFFFFFD, 32'h7, 0);
    alu_control = 12'h400; a = 32'h12345; b = 32'h6789; start = 1;
    @(posedge clock); #1;
    start = 0;
    repeat (10) @(posedge clock);
    #1;
    clear = 1;
    @(posedge clock); #1;
    clear = 0;
    chk("abort", {busy, done, div_zero, op_error, z_high, z_low}, '0);
    nd = 0;
    repeat (40) begin
      @(posedge clock); #1;
      nd += int'(done);
    end
    chk("abort_no_done", 64'(nd), 0);
    for (int i = 0; i < 60; i++) begin
      ctl = $urandom_range(0, 9) == 0 ? 12'($urandom) : 12'(1) << $urandom_range(0, 11);
      ra = pick();
      rb = (ctl[OP_DIV] && $urandom_range(0, 4) == 0) ? 32'h0 : pick();
      run($sformatf("rnd%0d", i), ctl, ra, rb, 1'($urandom_range(0, 1)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
